trap_unit: RTL and testbench

- Trap controller that sits directly upstream of the CSR file.
- Collects synchronous exceptions from the commit point and level-sensitive interrupt lines.
- Drains the pipeline, then drives csr_exception, csr_exception_cause and csr_exception_pc into the CSR block.
- Uses the CSR outputs csr_mie, csr_mtvec_mode and csr_mtvec_base to compute the trap redirect PC; also handles mret redirect to mepc.

---
 rtl/trap_unit_pkg.sv | 21 ++
 rtl/trap_unit_if.sv | 47 ++++
 rtl/trap_unit_irq_sync.sv | 28 ++
 rtl/trap_unit.sv | 143 ++++++++++++++
 tb/tb_trap_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_unit_pkg.sv
// Shared types and constants for the trap controller: state encoding,
// machine cause codes and the data word width.
package trap_unit_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_t;

  localparam logic [WORD_W-1:0] CAUSE_MISALIGNED = 32'd0;
  localparam logic [WORD_W-1:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [WORD_W-1:0] CAUSE_BREAK      = 32'd3;
  localparam logic [WORD_W-1:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [WORD_W-1:0] CAUSE_IRQ_TIMER  = 32'h8000_0007;
  localparam logic [WORD_W-1:0] CAUSE_IRQ_EXT    = 32'h8000_000B;

endpackage

// File: rtl/trap_unit_if.sv
// Bundle of commit-point, interrupt, CSR and fetch-redirect signals around
// the trap controller. The master modport is the trap unit itself; the
// slave modport is the surrounding pipeline / CSR file / fetch logic.
interface trap_unit_if;
  import trap_unit_pkg::*;

  logic              commit_valid;
  logic [WORD_W-1:0] commit_pc;
  logic              exc_misaligned;
  logic              exc_illegal;
  logic              exc_ebreak;
  logic              exc_ecall;
  logic              mret;
  logic              irq_timer;
  logic              irq_ext;
  logic              pipe_empty;
  logic              csr_mie;
  logic [1:0]        csr_mtvec_mode;
  logic [29:0]       csr_mtvec_base;
  logic [WORD_W-1:0] csr_mepc;
  logic              redirect_ready;

  logic              flush;
  logic              csr_exception;
  logic [WORD_W-1:0] csr_exception_cause;
  logic [WORD_W-1:0] csr_exception_pc;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              busy;

  modport master (
    input  commit_valid, commit_pc, exc_misaligned, exc_illegal, exc_ebreak,
           exc_ecall, mret, irq_timer, irq_ext, pipe_empty, csr_mie,
           csr_mtvec_mode, csr_mtvec_base, csr_mepc, redirect_ready,
    output flush, csr_exception, csr_exception_cause, csr_exception_pc,
           redirect_valid, redirect_pc, busy
  );

  modport slave (
    output commit_valid, commit_pc, exc_misaligned, exc_illegal, exc_ebreak,
           exc_ecall, mret, irq_timer, irq_ext, pipe_empty, csr_mie,
           csr_mtvec_mode, csr_mtvec_base, csr_mepc, redirect_ready,
    input  flush, csr_exception, csr_exception_cause, csr_exception_pc,
           redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/trap_unit_irq_sync.sv
// Flop chain that brings one asynchronous level interrupt into the clk
// domain. STAGES must be at least 1.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw line through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/trap_unit.sv
// Trap controller in front of the CSR file. Accepts exceptions and qualified
// interrupts at the commit point, drains the pipeline, pulses the CSR write,
// then redirects fetch to the trap vector (or to mepc for mret).
// Build option: define TRAP_VECTORED_EN to honour csr_mtvec_mode==1 and
// offset interrupt targets by 4*cause; otherwise every trap goes to the base.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2,
  parameter int DRAIN_MAX       = 15
) (
  input logic       clk,
  input logic       rst,
  trap_unit_if.master bus
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  trap_state_t       state, state_next;
  logic [CNT_W-1:0]  drain_cnt;
  logic [WORD_W-1:0] cause_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] target_q;
  logic [WORD_W-1:0] cause_sel;
  logic [WORD_W-1:0] vec_target;
  logic              trap_hit;
  logic              trap_take;
  logic              mret_take;
  logic              drain_done;
  logic              timer_sync;
  logic              ext_sync;
  logic              timer_pending;
  logic              ext_pending;

  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_timer (
    .clk (clk),
    .rst (rst),
    .d   (bus.irq_timer),
    .q   (timer_sync)
  );

  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_ext (
    .clk (clk),
    .rst (rst),
    .d   (bus.irq_ext),
    .q   (ext_sync)
  );

  assign timer_pending = timer_sync & bus.csr_mie;
  assign ext_pending   = ext_sync & bus.csr_mie;

  // Pick the highest-priority trap source; interrupts rank below all
  // synchronous exceptions.
  always_comb begin
    trap_hit  = 1'b1;
    cause_sel = '0;
    if (bus.exc_misaligned)   cause_sel = CAUSE_MISALIGNED;
    else if (bus.exc_illegal) cause_sel = CAUSE_ILLEGAL;
    else if (bus.exc_ebreak)  cause_sel = CAUSE_BREAK;
    else if (bus.exc_ecall)   cause_sel = CAUSE_ECALL_M;
    else if (ext_pending)     cause_sel = CAUSE_IRQ_EXT;
    else if (timer_pending)   cause_sel = CAUSE_IRQ_TIMER;
    else                      trap_hit  = 1'b0;
  end

  // Any trap, including a pending interrupt, takes precedence over mret.
  assign trap_take  = (state == IDLE) && bus.commit_valid && trap_hit;
  assign mret_take  = (state == IDLE) && bus.commit_valid && bus.mret && !trap_hit;
  assign drain_done = bus.pipe_empty || (drain_cnt == CNT_W'(DRAIN_MAX - 1));

`ifdef TRAP_VECTORED_EN
  // Vectored mode offsets interrupts by 4*cause; modes 2/3 behave as direct.
  always_comb begin
    vec_target = {bus.csr_mtvec_base, 2'b00};
    if (bus.csr_mtvec_mode == 2'd1 && cause_q[WORD_W-1]) begin
      vec_target = {bus.csr_mtvec_base, 2'b00} + {cause_q[WORD_W-3:0], 2'b00};
    end
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.csr_mtvec_mode;

  // Direct-only build: every trap lands on the base address.
  always_comb begin
    vec_target = {bus.csr_mtvec_base, 2'b00};
  end
`endif

  // Next-state sequencing through drain, CSR write and fetch redirect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trap_take)      state_next = DRAIN;
        else if (mret_take) state_next = REDIRECT;
      end
      DRAIN: begin
        if (drain_done) state_next = COMMIT;
      end
      COMMIT: begin
        state_next = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus latched cause/pc, drain watchdog and redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cause_q   <= '0;
      pc_q      <= '0;
      target_q  <= '0;
    end else begin
      state <= state_next;
      if (trap_take) begin
        cause_q   <= cause_sel;
        pc_q      <= bus.commit_pc;
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
      if (mret_take) begin
        target_q <= bus.csr_mepc;
      end else if (state == COMMIT) begin
        target_q <= vec_target;
      end
    end
  end

  assign bus.flush               = (state != IDLE);
  assign bus.busy                = (state != IDLE);
  assign bus.csr_exception       = (state == COMMIT);
  assign bus.csr_exception_cause = cause_q;
  assign bus.csr_exception_pc    = pc_q;
  assign bus.redirect_valid      = (state == REDIRECT);
  assign bus.redirect_pc         = target_q;

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit: reset values, exception and
// interrupt traps, priority, drain watchdog, redirect backpressure, mret
// and reset during a trap.
module tb_trap_unit;
  import trap_unit_pkg::*;

  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;

  trap_unit_if bus ();

  trap_unit #(.IRQ_SYNC_STAGES(2), .DRAIN_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] EXP_TIMER_TGT = 32'h21C;
  localparam logic [31:0] EXP_EXT_TGT   = 32'h22C;
`else
  localparam logic [31:0] EXP_TIMER_TGT = 32'h200;
  localparam logic [31:0] EXP_EXT_TGT   = 32'h200;
`endif

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic cv, input logic [31:0] pc,
                                input logic mis, input logic ill,
                                input logic brk, input logic ecl,
                                input logic mr);
    bus.commit_valid   = cv;
    bus.commit_pc      = pc;
    bus.exc_misaligned = mis;
    bus.exc_illegal    = ill;
    bus.exc_ebreak     = brk;
    bus.exc_ecall      = ecl;
    bus.mret           = mr;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    assert_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b1;
    idle_inputs();
    bus.irq_timer      = 1'b0;
    bus.irq_ext        = 1'b0;
    bus.pipe_empty     = 1'b1;
    bus.csr_mie        = 1'b1;
    bus.csr_mtvec_mode = 2'd1;
    bus.csr_mtvec_base = 30'h40;
    bus.csr_mepc       = 32'h0;
    bus.redirect_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check_output("rst_flush", {31'b0, bus.flush}, 32'h0);
    check_output("rst_busy", {31'b0, bus.busy}, 32'h0);
    check_output("rst_exc", {31'b0, bus.csr_exception}, 32'h0);
    check_output("rst_rv", {31'b0, bus.redirect_valid}, 32'h0);
    check_output("rst_cause", bus.csr_exception_cause, 32'h0);
    check_output("rst_pc", bus.csr_exception_pc, 32'h0);
    check_output("rst_rpc", bus.redirect_pc, 32'h0);
    rst = 1'b0;
    tick();

    // Illegal instruction, base 0x100
    apply_stimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    check_output("ill_drain_flush", {31'b0, bus.flush}, 32'h1);
    check_output("ill_drain_exc", {31'b0, bus.csr_exception}, 32'h0);
    tick();
    check_output("ill_commit_exc", {31'b0, bus.csr_exception}, 32'h1);
    check_output("ill_cause", bus.csr_exception_cause, 32'h2);
    check_output("ill_pc", bus.csr_exception_pc, 32'h100);
    tick();
    check_output("ill_rv", {31'b0, bus.redirect_valid}, 32'h1);
    check_output("ill_rpc", bus.redirect_pc, 32'h100);
    check_output("ill_exc_once", {31'b0, bus.csr_exception}, 32'h0);
    tick();
    check_output("ill_idle", {31'b0, bus.busy}, 32'h0);

    // Timer interrupt through the 2-stage synchronizer, base 0x200
    bus.csr_mtvec_base = 30'h80;
    bus.irq_timer = 1'b1;
    apply_stimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("tmr_sync1", {31'b0, bus.busy}, 32'h0);
    tick();
    check_output("tmr_sync2", {31'b0, bus.busy}, 32'h0);
    tick();
    check_output("tmr_accept", {31'b0, bus.busy}, 32'h1);
    idle_inputs();
    tick();
    check_output("tmr_exc", {31'b0, bus.csr_exception}, 32'h1);
    check_output("tmr_cause", bus.csr_exception_cause, 32'h8000_0007);
    check_output("tmr_pc", bus.csr_exception_pc, 32'h300);
    tick();
    check_output("tmr_rpc", bus.redirect_pc, EXP_TIMER_TGT);
    tick();
    bus.irq_timer = 1'b0;
    tick();
    tick();
    tick();

    // Timer interrupt masked by csr_mie=0
    bus.csr_mie = 1'b0;
    bus.irq_timer = 1'b1;
    apply_stimulus(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_output("mie0_busy", {31'b0, bus.busy}, 32'h0);
    idle_inputs();
    bus.irq_timer = 1'b0;
    tick();
    tick();
    tick();
    bus.csr_mie = 1'b1;

    // ecall + illegal + synced ext irq together: illegal first, irq after
    bus.irq_ext = 1'b1;
    tick();
    tick();
    apply_stimulus(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    check_output("sim_cause", bus.csr_exception_cause, 32'h2);
    check_output("sim_pc", bus.csr_exception_pc, 32'h500);
    tick();
    check_output("sim_rpc", bus.redirect_pc, 32'h200);
    tick();
    check_output("sim_idle", {31'b0, bus.busy}, 32'h0);
    apply_stimulus(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    check_output("ext_accept", {31'b0, bus.busy}, 32'h1);
    tick();
    check_output("ext_exc", {31'b0, bus.csr_exception}, 32'h1);
    check_output("ext_cause", bus.csr_exception_cause, 32'h8000_000B);
    check_output("ext_pc", bus.csr_exception_pc, 32'h504);
    tick();
    check_output("ext_rpc", bus.redirect_pc, EXP_EXT_TGT);
    tick();
    bus.irq_ext = 1'b0;
    tick();
    tick();
    tick();

    // Drain watchdog with pipe never empty, then redirect backpressure
    bus.pipe_empty = 1'b0;
    apply_stimulus(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    n = 0;
    while (!bus.csr_exception && n < 40) begin
      tick();
      n++;
    end
    check_output("wd_drain_cycles", n, 32'd15);
    check_output("wd_cause", bus.csr_exception_cause, 32'd11);
    bus.redirect_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("bp_rv", {31'b0, bus.redirect_valid}, 32'h1);
      check_output("bp_rpc", bus.redirect_pc, 32'h200);
      tick();
    end
    check_output("bp_still_rv", {31'b0, bus.redirect_valid}, 32'h1);
    bus.redirect_ready = 1'b1;
    tick();
    check_output("bp_idle", {31'b0, bus.busy}, 32'h0);
    bus.pipe_empty = 1'b1;

    // mret alone: straight to redirect with mepc, no CSR pulse
    bus.csr_mepc = 32'h88;
    apply_stimulus(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    check_output("mret_exc", {31'b0, bus.csr_exception}, 32'h0);
    check_output("mret_rv", {31'b0, bus.redirect_valid}, 32'h1);
    check_output("mret_rpc", bus.redirect_pc, 32'h88);
    tick();
    check_output("mret_idle", {31'b0, bus.busy}, 32'h0);

    // mret with illegal: exception wins
    apply_stimulus(1'b1, 32'h704, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    check_output("mret_ill_drain", {31'b0, bus.redirect_valid}, 32'h0);
    tick();
    check_output("mret_ill_exc", {31'b0, bus.csr_exception}, 32'h1);
    check_output("mret_ill_cause", bus.csr_exception_cause, 32'h2);
    tick();
    tick();

    // Reset while draining aborts with no CSR pulse
    bus.pipe_empty = 1'b0;
    apply_stimulus(1'b1, 32'h800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    tick();
    check_output("rd_in_drain", {31'b0, bus.busy}, 32'h1);
    rst = 1'b1;
    tick();
    check_output("rd_busy", {31'b0, bus.busy}, 32'h0);
    check_output("rd_flush", {31'b0, bus.flush}, 32'h0);
    check_output("rd_cause", bus.csr_exception_cause, 32'h0);
    check_output("rd_pc", bus.csr_exception_pc, 32'h0);
    check_output("rd_rpc", bus.redirect_pc, 32'h0);
    rst = 1'b0;
    bus.pipe_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output("rd_no_exc", {31'b0, bus.csr_exception}, 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_cnt, fail_cnt);
    $finish;
  end

endmodule
